// File: rtl/ps2_kbd_ctrl_if.sv
// Key-event channel from ps2_kbd_ctrl to the downstream display/ASCII stage.
// valid/ready handshake; payload is held stable while valid is high and ready is low.
interface ps2_kbd_ctrl_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;

  modport master (output evt_valid, output evt_code, output evt_ext, output evt_break,
                  input  evt_ready);
  modport slave  (input  evt_valid, input  evt_code, input  evt_ext, input  evt_break,
                  output evt_ready);
endinterface

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 scan-code sequencer: pops ps2_keyboard bytes, merges E0/F0 prefixes into key events.
// Optional TYPEMATIC_FILTER_EN drops auto-repeat makes of the currently held key.
module ps2_kbd_ctrl #(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned PREFIX_TO = 1000000
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [7:0]       kbd_data,
  input  logic             kbd_ready,
  input  logic             kbd_overflow,
  output logic             kbd_nextdata_n,
  ps2_kbd_ctrl_if.master   evt,
  output logic             key_down,
  output logic [8:0]       held_code,
  output logic [CNT_W-1:0] press_cnt,
  output logic             ovf_sticky,
  input  logic             ovf_clr
);

  localparam int unsigned TO_W = (PREFIX_TO > 2) ? $clog2(PREFIX_TO) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(PREFIX_TO - 1);

  typedef enum logic [2:0] {
    IDLE,
    POP,
    GAP,
    DECODE,
    EMIT
  } state_t;

  state_t          state, state_nxt;
  logic [7:0]      byte_r;
  logic            ext_p, brk_p;
  logic [TO_W-1:0] to_cnt;
  logic            evt_valid_r, evt_ext_r, evt_break_r;
  logic [7:0]      evt_code_r;

  logic is_e0, is_f0, is_err, emit_byte, accept;

  assign evt.evt_valid = evt_valid_r;
  assign evt.evt_code  = evt_code_r;
  assign evt.evt_ext   = evt_ext_r;
  assign evt.evt_break = evt_break_r;

  always_comb begin
    is_e0     = (byte_r == 8'hE0);
    is_f0     = (byte_r == 8'hF0);
    is_err    = (byte_r == 8'h00) || (byte_r == 8'hFF) || (byte_r == 8'hAA);
`ifdef TYPEMATIC_FILTER_EN
    emit_byte = !is_e0 && !is_f0 && !is_err &&
                !(key_down && !brk_p && (held_code == {ext_p, byte_r}));
`else
    emit_byte = !is_e0 && !is_f0 && !is_err;
`endif
    accept    = (state == EMIT) && evt.evt_ready;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (kbd_ready) state_nxt = POP;
      POP:     state_nxt = GAP;
      GAP:     state_nxt = DECODE;
      DECODE:  state_nxt = emit_byte ? EMIT : IDLE;
      EMIT:    if (evt.evt_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      kbd_nextdata_n <= 1'b1;
      byte_r         <= '0;
      ext_p          <= 1'b0;
      brk_p          <= 1'b0;
      to_cnt         <= '0;
      evt_valid_r    <= 1'b0;
      evt_code_r     <= '0;
      evt_ext_r      <= 1'b0;
      evt_break_r    <= 1'b0;
      key_down       <= 1'b0;
      held_code      <= '0;
      press_cnt      <= '0;
      ovf_sticky     <= 1'b0;
    end else begin
      // Strobe is registered from the next state so it is low exactly while in POP.
      kbd_nextdata_n <= (state_nxt != POP);

      if (kbd_overflow)  ovf_sticky <= 1'b1;
      else if (ovf_clr)  ovf_sticky <= 1'b0;

      unique case (state)
        IDLE: begin
          if (kbd_ready) begin
            byte_r <= kbd_data;
            to_cnt <= '0;
          end else if (ext_p || brk_p) begin
            if (to_cnt == TO_LAST) begin
              ext_p  <= 1'b0;
              brk_p  <= 1'b0;
              to_cnt <= '0;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
        end
        DECODE: begin
          if (is_e0) begin
            ext_p <= 1'b1;
          end else if (is_f0) begin
            brk_p <= 1'b1;
          end else begin
            ext_p <= 1'b0;
            brk_p <= 1'b0;
            if (emit_byte) begin
              evt_code_r  <= byte_r;
              evt_ext_r   <= ext_p;
              evt_break_r <= brk_p;
              evt_valid_r <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (accept) begin
            evt_valid_r <= 1'b0;
            if (!evt_break_r) begin
              key_down  <= 1'b1;
              held_code <= {evt_ext_r, evt_code_r};
              press_cnt <= press_cnt + 1'b1;
            end else if (held_code == {evt_ext_r, evt_code_r}) begin
              key_down <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed bench for ps2_kbd_ctrl with a behavioural ps2_keyboard FIFO and event logger.
// Expectations follow TYPEMATIC_FILTER_EN when it is defined for the build.
module tb_ps2_kbd_ctrl;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned PREFIX_TO = 20;

  logic             clk = 1'b0;
  logic             clrn;
  logic [7:0]       kbd_data;
  logic             kbd_ready;
  logic             kbd_overflow;
  logic             kbd_nextdata_n;
  logic             key_down;
  logic [8:0]       held_code;
  logic [CNT_W-1:0] press_cnt;
  logic             ovf_sticky;
  logic             ovf_clr;

  ps2_kbd_ctrl_if evt_if ();

  ps2_kbd_ctrl #(.CNT_W(CNT_W), .PREFIX_TO(PREFIX_TO)) dut (
    .clk            (clk),
    .clrn           (clrn),
    .kbd_data       (kbd_data),
    .kbd_ready      (kbd_ready),
    .kbd_overflow   (kbd_overflow),
    .kbd_nextdata_n (kbd_nextdata_n),
    .evt            (evt_if),
    .key_down       (key_down),
    .held_code      (held_code),
    .press_cnt      (press_cnt),
    .ovf_sticky     (ovf_sticky),
    .ovf_clr        (ovf_clr)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] q[$];
  logic [9:0] ev[$];   // {ext, break, code}
  int         pulses, run_len, max_run;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] get_ev(input int i);
    return (ev.size() > i) ? ev[i] : 10'h3FF;
  endfunction

  task automatic fifo_upd();
    kbd_ready = (q.size() != 0);
    kbd_data  = (q.size() != 0) ? q[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    q.push_back(b);
    fifo_upd();
  endtask

  // Observe the values that the coming posedge will act on, then advance to the next negedge.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      if (evt_if.evt_valid && evt_if.evt_ready)
        ev.push_back({evt_if.evt_ext, evt_if.evt_break, evt_if.evt_code});
      if (!kbd_nextdata_n) begin
        if (q.size() != 0) void'(q.pop_front());
        run_len++;
        if (run_len == 1) pulses++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
      @(negedge clk);
      fifo_upd();
    end
  endtask

  task automatic wait_ev(input int n, input int budget);
    int k = 0;
    while (ev.size() < n && k < budget) begin
      cyc(1);
      k++;
    end
  endtask

  task automatic do_reset();
    clrn             = 1'b0;
    q.delete();
    fifo_upd();
    evt_if.evt_ready = 1'b1;
    kbd_overflow     = 1'b0;
    ovf_clr          = 1'b0;
    cyc(2);
    clrn = 1'b1;
    cyc(1);
    ev.delete();
    pulses  = 0;
    run_len = 0;
    max_run = 0;
  endtask

  initial begin
    int bad;
    clrn             = 1'b0;
    kbd_overflow     = 1'b0;
    ovf_clr          = 1'b0;
    evt_if.evt_ready = 1'b1;
    kbd_data         = 8'h00;
    kbd_ready        = 1'b0;
    pulses = 0; run_len = 0; max_run = 0;
    @(negedge clk);
    cyc(2);
    check("rst_nextdata_n", kbd_nextdata_n, 1);
    check("rst_valid",      evt_if.evt_valid, 0);
    check("rst_code",       evt_if.evt_code, 0);
    check("rst_ext_brk",    {evt_if.evt_ext, evt_if.evt_break}, 0);
    check("rst_key_down",   key_down, 0);
    check("rst_held",       held_code, 0);
    check("rst_press",      press_cnt, 0);
    check("rst_ovf",        ovf_sticky, 0);

    // Single make
    do_reset();
    push(8'h1C);
    wait_ev(1, 30);
    cyc(5);
    check("t1_ev_cnt",   ev.size(), 1);
    check("t1_ev0",      get_ev(0), 10'h01C);
    check("t1_key_down", key_down, 1);
    check("t1_held",     held_code, 9'h01C);
    check("t1_press",    press_cnt, 1);
    check("t1_pulses",   pulses, 1);
    check("t1_pulse_len", max_run, 1);

    // Make then break
    do_reset();
    push(8'h1C); push(8'hF0); push(8'h1C);
    wait_ev(2, 60);
    cyc(5);
    check("t2_ev_cnt",   ev.size(), 2);
    check("t2_ev0",      get_ev(0), 10'h01C);
    check("t2_ev1",      get_ev(1), 10'h11C);
    check("t2_key_down", key_down, 0);
    check("t2_press",    press_cnt, 1);
    check("t2_pulses",   pulses, 3);

    // Extended make / break
    do_reset();
    push(8'hE0); push(8'h75); push(8'hE0); push(8'hF0); push(8'h75);
    wait_ev(1, 60);
    check("t3_ev0",      get_ev(0), 10'h275);
    check("t3_held",     held_code, 9'h175);
    check("t3_key_mid",  key_down, 1);
    wait_ev(2, 60);
    cyc(3);
    check("t3_ev1",      get_ev(1), 10'h375);
    check("t3_key_end",  key_down, 0);
    check("t3_press",    press_cnt, 1);

    // Backpressure
    do_reset();
    evt_if.evt_ready = 1'b0;
    push(8'h1C); push(8'h1B);
    cyc(10);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (!evt_if.evt_valid || evt_if.evt_code != 8'h1C) bad++;
    end
    check("t4_stall_stable", bad, 0);
    check("t4_no_pop",   pulses, 1);
    check("t4_no_ev",    ev.size(), 0);
    evt_if.evt_ready = 1'b1;
    wait_ev(2, 60);
    cyc(3);
    check("t4_ev0",      get_ev(0), 10'h01C);
    check("t4_ev1",      get_ev(1), 10'h01B);
    check("t4_press",    press_cnt, 2);
    check("t4_held",     held_code, 9'h01B);

    // Prefix timeout, prefix kept inside the window, error byte drop
    do_reset();
    push(8'hF0);
    cyc(PREFIX_TO + 15);
    push(8'h1C);
    wait_ev(1, 30);
    check("t5_timeout_ev", get_ev(0), 10'h01C);
    do_reset();
    push(8'hF0);
    cyc(PREFIX_TO / 2);
    push(8'h1C);
    wait_ev(1, 30);
    check("t5_window_ev", get_ev(0), 10'h11C);
    do_reset();
    push(8'hE0); push(8'hAA); push(8'h1C);
    wait_ev(1, 40);
    cyc(10);
    check("t5_drop_cnt", ev.size(), 1);
    check("t5_drop_ev",  get_ev(0), 10'h01C);

    // Overflow sticky
    kbd_overflow = 1'b1; cyc(1); kbd_overflow = 1'b0;
    check("ovf_set",  ovf_sticky, 1);
    cyc(3);
    check("ovf_hold", ovf_sticky, 1);
    kbd_overflow = 1'b1; ovf_clr = 1'b1; cyc(1);
    kbd_overflow = 1'b0; ovf_clr = 1'b0;
    check("ovf_set_wins", ovf_sticky, 1);
    ovf_clr = 1'b1; cyc(1); ovf_clr = 1'b0;
    check("ovf_clr", ovf_sticky, 0);

    // Typematic repeat, then async reset mid-EMIT
    do_reset();
    push(8'h1C); push(8'h1C); push(8'h1C);
    wait_ev(3, 80);
    cyc(5);
`ifdef TYPEMATIC_FILTER_EN
    check("t6_ev_cnt", ev.size(), 1);
    check("t6_press",  press_cnt, 1);
`else
    check("t6_ev_cnt", ev.size(), 3);
    check("t6_press",  press_cnt, 3);
`endif
    check("t6_ev0", get_ev(0), 10'h01C);
    kbd_overflow = 1'b1; cyc(1); kbd_overflow = 1'b0;
    evt_if.evt_ready = 1'b0;
    push(8'h1B);
    cyc(10);
    check("t6_emit_valid", evt_if.evt_valid, 1);
    check("t6_emit_code",  evt_if.evt_code, 8'h1B);
    clrn = 1'b0;
    #1;
    check("t6_rst_valid",  evt_if.evt_valid, 0);
    check("t6_rst_code",   evt_if.evt_code, 0);
    check("t6_rst_key",    key_down, 0);
    check("t6_rst_held",   held_code, 0);
    check("t6_rst_press",  press_cnt, 0);
    check("t6_rst_ovf",    ovf_sticky, 0);
    check("t6_rst_ndn",    kbd_nextdata_n, 1);
    @(negedge clk);
    clrn = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
